// File: rtl/alioth_mem_arb_pkg.sv
// Shared definitions for the alioth two-requester memory arbiter:
// FSM state encoding and requester index constants.
package alioth_mem_arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RSP  = 2'd2
   } arb_state_t;

   // Requester indices. The owner and last-grant bits hold one of these.
   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

   // Map a one-hot grant vector to a requester index.
   function automatic logic grant_index(input logic [1:0] grant);
      return grant[1] ? ARB_M1 : ARB_M0;
   endfunction

endpackage

// File: rtl/alioth_rr_pick2.sv
// Combinational two-way round-robin picker. When both requesters are
// valid, the one that was not granted last time wins.
module alioth_rr_pick2
   import alioth_mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   // One-hot grant: a lone requester always wins; a tie goes to the non-last one.
   always_comb begin
      grant = 2'b00;
      if (valid[0] && valid[1]) begin
         if (last == ARB_M1) begin
            grant[0] = 1'b1;
         end else begin
            grant[1] = 1'b1;
         end
      end else begin
         grant = valid;
      end
   end

endmodule

// File: rtl/alioth_mem_arb.sv
// Two-requester memory arbiter. Grants m0 (instruction fetch) or m1
// (load/store) round-robin, keeps a single transaction in flight through
// the downstream request/response handshake, and routes the response
// back to the requester that owns it.
module alioth_mem_arb
   import alioth_mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic                clk,
   input  logic                rst,

   input  logic                m0_req_valid,
   output logic                m0_req_ready,
   input  logic [ADDR_W-1:0]   m0_req_addr,
   input  logic                m0_req_we,
   input  logic [DATA_W-1:0]   m0_req_wdata,
   input  logic [DATA_W/8-1:0] m0_req_wstrb,
   output logic                m0_rsp_valid,
   output logic [DATA_W-1:0]   m0_rsp_rdata,

   input  logic                m1_req_valid,
   output logic                m1_req_ready,
   input  logic [ADDR_W-1:0]   m1_req_addr,
   input  logic                m1_req_we,
   input  logic [DATA_W-1:0]   m1_req_wdata,
   input  logic [DATA_W/8-1:0] m1_req_wstrb,
   output logic                m1_rsp_valid,
   output logic [DATA_W-1:0]   m1_rsp_rdata,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_we,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_rdata
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_t          state_reg;
   arb_state_t          state_next;
   logic                owner_reg;
   logic                last_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic                we_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [STRB_W-1:0]   wstrb_reg;

   logic [1:0]          req_valid;
   logic [1:0]          grant;
   logic                grant_fire;
   logic                rsp_fire;

   logic [1:0]          rsp_valid_reg;
   logic [DATA_W-1:0]   rsp_rdata_reg [2];

   assign req_valid = {m1_req_valid, m0_req_valid};

   alioth_rr_pick2 u_pick (
      .valid (req_valid),
      .last  (last_reg),
      .grant (grant)
   );

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ARB_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake decode. Responses outside RSP are ignored.
   always_comb begin
      state_next    = state_reg;
      grant_fire    = 1'b0;
      rsp_fire      = 1'b0;
      mem_req_valid = 1'b0;
      case (state_reg)
         ARB_IDLE: begin
            if (|grant) begin
               grant_fire = 1'b1;
               state_next = ARB_REQ;
            end
         end
         ARB_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_next = ARB_RSP;
            end
         end
         ARB_RSP: begin
            if (mem_rsp_valid) begin
               rsp_fire   = 1'b1;
               state_next = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Ready is masked while reset is held so every output reads 0 during reset,
   // even though the FSM sits in IDLE with requesters possibly still valid.
   assign m0_req_ready = grant_fire & grant[0] & ~rst;
   assign m1_req_ready = grant_fire & grant[1] & ~rst;

   // Capture the granted request and record ownership / round-robin history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_reg <= ARB_M0;
         last_reg  <= ARB_M1;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         wdata_reg <= '0;
         wstrb_reg <= '0;
      end else if (grant_fire) begin
         owner_reg <= grant_index(grant);
         last_reg  <= grant_index(grant);
         addr_reg  <= grant[1] ? m1_req_addr  : m0_req_addr;
         we_reg    <= grant[1] ? m1_req_we    : m0_req_we;
         wdata_reg <= grant[1] ? m1_req_wdata : m0_req_wdata;
         wstrb_reg <= grant[1] ? m1_req_wstrb : m0_req_wstrb;
      end
   end

   assign mem_req_addr  = addr_reg;
   assign mem_req_we    = we_reg;
   assign mem_req_wdata = wdata_reg;
   assign mem_req_wstrb = wstrb_reg;

   // Per-requester response registers: one-cycle valid pulse, data held
   // until the next response to the same requester.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      localparam logic IDX = (gi == 1) ? ARB_M1 : ARB_M0;

      // Pulse valid and load read data (zero for writes) for the owner only.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rsp_valid_reg[gi] <= 1'b0;
            rsp_rdata_reg[gi] <= '0;
         end else begin
            rsp_valid_reg[gi] <= rsp_fire && (owner_reg == IDX);
            if (rsp_fire && (owner_reg == IDX)) begin
               rsp_rdata_reg[gi] <= we_reg ? '0 : mem_rsp_rdata;
            end
         end
      end
   end

   assign m0_rsp_valid = rsp_valid_reg[0];
   assign m1_rsp_valid = rsp_valid_reg[1];
   assign m0_rsp_rdata = rsp_rdata_reg[0];
   assign m1_rsp_rdata = rsp_rdata_reg[1];

endmodule

// File: doc/alioth_mem_arb.md
# alioth_mem_arb

Two-requester memory arbiter for the alioth SoC. It sits between `cpu_top`'s instruction-fetch port (m0) and load/store port (m1) and one shared single-port memory or bus interface. It picks one requester with round-robin priority and keeps one transaction in flight. It sequences the downstream request/response handshake and routes the response back to the owning requester.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m0_req_valid`, `m1_req_valid`  in  1  requester has a request
- `m0_req_ready`, `m1_req_ready`  out  1  request accepted this cycle
- `mX_req_addr`  in  ADDR_W  byte address
- `mX_req_we`  in  1  1 = write
- `mX_req_wdata`  in  DATA_W  write data
- `mX_req_wstrb`  in  DATA_W/8  byte enables; ignored on reads
- `mX_rsp_valid`  out  1  one-cycle response pulse; the requester always accepts it
- `mX_rsp_rdata`  out  DATA_W  read data; 0 for writes
- `mem_req_valid`  out  1  downstream request
- `mem_req_ready`  in  1  downstream accepts
- `mem_req_addr`, `mem_req_we`, `mem_req_wdata`, `mem_req_wstrb`  out  captured request fields
- `mem_rsp_valid`  in  1  downstream response, including write acknowledge
- `mem_rsp_rdata`  in  DATA_W  downstream read data

## Operation
- FSM has three states: IDLE, REQ, RSP. A `owner` bit records the granted requester. A `last` bit records the previous grant.
- IDLE:
  - If exactly one `mX_req_valid` is high, grant it.
  - If both are high, grant the requester that is not `last`.
  - On a grant, drive `mX_req_ready`=1 combinationally for that requester only. The same edge captures its addr, we, wdata and wstrb, sets `owner` and `last`, and moves to REQ.
- REQ: `mem_req_valid`=1 with the captured fields. On `mem_req_valid && mem_req_ready`, move to RSP.
- RSP: wait for `mem_rsp_valid`. On that edge:
  - Register `mem_rsp_rdata` (forced to 0 if we=1) into the owner's rdata.
  - Pulse the owner's `rsp_valid` for the next cycle.
  - Return to IDLE.
- `req_ready` is never asserted outside IDLE. Only one transaction is ever outstanding.
- `mem_rsp_valid` outside RSP is ignored. It must not produce a response or change state.
- Response data registers hold their value until the next response to the same requester.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - `last`=1, so m0 wins the first tie.
  - Captured fields and rdata are 0.
- Reset mid-transaction aborts it. No response is issued. Downstream must also be reset.
- Minimum latency, accept to response:
  - Cycle 0: accept in IDLE.
  - Cycle 1: `mem_req_valid`, with `mem_req_ready`=1.
  - Cycle 2: `mem_rsp_valid`.
  - Cycle 3: `mX_rsp_valid`.
- The FSM is in IDLE during cycle 3, so a new grant can coincide with a response pulse.
- Back-to-back throughput is one transaction per 3 cycles minimum.
- Downstream stalls extend REQ or RSP indefinitely. Captured outputs stay stable while `mem_req_valid` is held.
- Round-robin is strict: with both requesters permanently requesting, grants alternate m0, m1, m0, ...

## Structure
- Shared package `alioth_mem_arb_pkg`: FSM state encoding (`ARB_IDLE`=2'd0, `ARB_REQ`=2'd1, `ARB_RSP`=2'd2) and the requester index constants `ARB_M0`/`ARB_M1`.
- One sub-module is natural: `alioth_rr_pick2`. It is combinational; inputs are the two valids and `last`, outputs are the grant one-hot.
- Everything else stays in a single always-block FSM plus capture registers.

## Test plan
- Single m0 read, addr 0x100, with downstream ready and response immediate:
  - `m0_req_ready` in cycle 0, `mem_req_valid` in cycle 1, `m0_rsp_valid` in cycle 3.
  - `m0_rsp_rdata`=0xDEADBEEF. m1 sees no activity.
- Both requesting continuously from reset, 4 transactions: grant order m0, m1, m0, m1, and each `rsp_valid` goes to the matching requester.
- m1 write, wdata 0x12345678, wstrb 4'b0011:
  - Downstream receives exactly those fields.
  - `m1_rsp_rdata`=0 despite `mem_rsp_rdata`=0xFFFFFFFF.
- `mem_req_ready` low for 5 cycles: `mem_req_*` stay stable, no `req_ready` is asserted, and the transaction completes after ready rises.
- Spurious `mem_rsp_valid` in IDLE: no `rsp_valid` pulse and no state change.
- Assert `rst` while in RSP:
  - All outputs go to 0 immediately.
  - After release, both requesting grants m0 first and no stale response appears.
